// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and helpers for the LCD status display.
// Holds mode codes, ASCII codes, the DDRAM address map and the mode-name lookup.
package lcd_pkg;

    localparam logic [2:0] MODE_DEFAULT = 3'd0;
    localparam logic [2:0] MODE_PLAY    = 3'd1;
    localparam logic [2:0] MODE_PAUSE   = 3'd2;
    localparam logic [2:0] MODE_STOP    = 3'd3;
    localparam logic [2:0] MODE_RECORD  = 3'd4;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_BLANK = 8'h20;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_Y     = 8'h59;

    typedef enum logic [2:0] {
        ST_SNAP,
        ST_FMT,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    function automatic logic [7:0] lcd_addr(input logic [1:0] row, input logic [5:0] col);
        return {row, 6'b0} + {2'b00, col};
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_0 + {4'b0000, d};
    endfunction

    // Mode name occupies the first six columns; unknown codes read as IDLE.
    function automatic logic [7:0] mode_char(input logic [2:0] mode, input logic [5:0] col);
        logic [47:0] txt;
        case (mode)
            MODE_PLAY:   txt = {ASCII_P, ASCII_L, ASCII_A, ASCII_Y, ASCII_BLANK, ASCII_BLANK};
            MODE_PAUSE:  txt = {ASCII_P, ASCII_A, ASCII_U, ASCII_S, ASCII_E, ASCII_BLANK};
            MODE_STOP:   txt = {ASCII_S, ASCII_T, ASCII_O, ASCII_P, ASCII_BLANK, ASCII_BLANK};
            MODE_RECORD: txt = {ASCII_R, ASCII_E, ASCII_C, ASCII_O, ASCII_R, ASCII_D};
            default:     txt = {ASCII_I, ASCII_D, ASCII_L, ASCII_E, ASCII_BLANK, ASCII_BLANK};
        endcase
        if (col < 6'd6) begin
            return txt[47 - 8 * int'(col) -: 8];
        end
        return ASCII_BLANK;
    endfunction

endpackage

// File: rtl/sample_to_mmss.sv
// Converts a sample count to MM:SS digits with one registered stage.
// Minutes above 99 saturate the whole field to 99:59.
module sample_to_mmss
    import lcd_pkg::*;
#(
    parameter int SR_SHIFT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_count,
    output mmss_t       o_mmss
);

    logic [31:0] secs_total;
    logic [31:0] minutes;
    logic [6:0]  mm;
    logic [6:0]  ss;
    mmss_t       mmss_d;
    mmss_t       mmss_q;

    always_comb begin
        secs_total = i_count >> SR_SHIFT;
        minutes    = secs_total / 32'd60;
        if (minutes > 32'd99) begin
            mm = 7'd99;
            ss = 7'd59;
        end else begin
            mm = minutes[6:0];
            ss = 7'(secs_total % 32'd60);
        end
        mmss_d.min_tens = 4'(mm / 7'd10);
        mmss_d.min_ones = 4'(mm % 7'd10);
        mmss_d.sec_tens = 4'(ss / 7'd10);
        mmss_d.sec_ones = 4'(ss % 7'd10);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mmss_q <= '0;
        end else begin
            mmss_q <= mmss_d;
        end
    end

    assign o_mmss = mmss_q;

endmodule

// File: rtl/lcd_status_display.sv
// Scans a status frame cell by cell against a shadow of the LCD contents and
// issues character writes only for cells that changed or were invalidated.
module lcd_status_display
    import lcd_pkg::*;
#(
    parameter int N_ROWS   = 2,
    parameter int N_COLS   = 16,
    parameter int SR_SHIFT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_status_para,
    input  logic [63:0] i_time_para,
    input  logic        i_busy,
    input  logic        i_force,
    output logic [7:0]  o_character,
    output logic [7:0]  o_address,
    output logic        o_start,
    output logic        o_frame_done
);

    localparam int         N_CELLS   = N_ROWS * N_COLS;
    localparam int         CELL_W    = $clog2(N_CELLS);
    localparam logic [5:0] COL_LAST  = 6'(N_COLS - 1);
    localparam logic [5:0] COL_X     = 6'(N_COLS - 2);
    localparam logic [1:0] ROW_END   = 2'(N_ROWS);
    localparam logic [1:0] TIME_ROW  = 2'(N_ROWS - 1);
    localparam logic [5:0] TIME_COL0 = (N_ROWS == 2) ? 6'd0 : 6'(N_COLS - 11);

    state_t              state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic [3:0]          speed_q, speed_d;
    logic [63:0]         time_q, time_d;
    logic                force_q, force_d;
    logic [1:0]          row_q, row_d;
    logic [5:0]          col_q, col_d;
    logic [1:0]          wait_q, wait_d;
    logic                start_q, start_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          char_q, char_d;
    logic [7:0]          addr_q, addr_d;
    logic [N_CELLS-1:0]  valid_q, valid_d;
    logic [7:0]          shadow_q [N_CELLS];
    logic [7:0]          shadow_d [N_CELLS];

    mmss_t               cur_mmss;
    mmss_t               tot_mmss;
    logic [CELL_W-1:0]   cell_idx;
    logic [7:0]          target;
    logic [3:0]          time_pos;
    logic                cell_dirty;
    logic [1:0]          adv_row;
    logic [5:0]          adv_col;
    logic                unused_status_bits;

    assign unused_status_bits = ^{i_status_para[15:12], i_status_para[7:3]};

    sample_to_mmss #(.SR_SHIFT(SR_SHIFT)) u_cur (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_count (time_q[63:32]),
        .o_mmss  (cur_mmss)
    );

    sample_to_mmss #(.SR_SHIFT(SR_SHIFT)) u_tot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_count (time_q[31:0]),
        .o_mmss  (tot_mmss)
    );

    assign cell_idx   = CELL_W'(int'(row_q) * N_COLS + int'(col_q));
    assign cell_dirty = !valid_q[cell_idx] || (shadow_q[cell_idx] != target);

    // Time text wins over the mode/speed fields when they share a row.
    always_comb begin
        target   = ASCII_BLANK;
        time_pos = 4'd0;
        if (row_q == 2'd0) begin
            target = mode_char(mode_q, col_q);
            if (mode_q == MODE_PLAY) begin
                if (col_q == COL_X) begin
                    target = ASCII_X;
                end else if (col_q == COL_LAST) begin
                    target = digit_char(speed_q);
                end
            end
        end
        if ((row_q == TIME_ROW) && (col_q >= TIME_COL0) && ((col_q - TIME_COL0) < 6'd11)) begin
            time_pos = 4'(col_q - TIME_COL0);
            case (time_pos)
                4'd0:    target = digit_char(cur_mmss.min_tens);
                4'd1:    target = digit_char(cur_mmss.min_ones);
                4'd2:    target = ASCII_COLON;
                4'd3:    target = digit_char(cur_mmss.sec_tens);
                4'd4:    target = digit_char(cur_mmss.sec_ones);
                4'd5:    target = ASCII_SLASH;
                4'd6:    target = digit_char(tot_mmss.min_tens);
                4'd7:    target = digit_char(tot_mmss.min_ones);
                4'd8:    target = ASCII_COLON;
                4'd9:    target = digit_char(tot_mmss.sec_tens);
                default: target = digit_char(tot_mmss.sec_ones);
            endcase
        end
    end

    always_comb begin
        if (col_q == COL_LAST) begin
            adv_col = 6'd0;
            adv_row = row_q + 2'd1;
        end else begin
            adv_col = col_q + 6'd1;
            adv_row = row_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        speed_d      = speed_q;
        time_d       = time_q;
        force_d      = force_q | i_force;
        row_d        = row_q;
        col_d        = col_q;
        wait_d       = wait_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        char_d       = char_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        shadow_d     = shadow_q;
        case (state_q)
            ST_SNAP: begin
                mode_d  = i_status_para[2:0];
                speed_d = i_status_para[11:8];
                time_d  = i_time_para;
                if (force_q) begin
                    valid_d = '0;
                end
                force_d = i_force;
                row_d   = 2'd0;
                col_d   = 6'd0;
                state_d = ST_FMT;
            end
            ST_FMT: begin
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (row_q == ROW_END) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_SNAP;
                end else if (cell_dirty) begin
                    state_d = ST_ISSUE;
                end else begin
                    row_d = adv_row;
                    col_d = adv_col;
                end
            end
            ST_ISSUE: begin
                if (!i_busy) begin
                    char_d             = target;
                    addr_d             = lcd_addr(row_q, col_q);
                    start_d            = 1'b1;
                    shadow_d[cell_idx] = target;
                    valid_d[cell_idx]  = 1'b1;
                    wait_d             = 2'd0;
                    state_d            = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (i_busy || (wait_q == 2'd3)) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_WAIT_LO: begin
                if (!i_busy) begin
                    row_d   = adv_row;
                    col_d   = adv_col;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_SNAP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_SNAP;
            mode_q       <= MODE_DEFAULT;
            speed_q      <= 4'd0;
            time_q       <= 64'd0;
            force_q      <= 1'b0;
            row_q        <= 2'd0;
            col_q        <= 6'd0;
            wait_q       <= 2'd0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            char_q       <= ASCII_BLANK;
            addr_q       <= 8'h00;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            time_q       <= time_d;
            force_q      <= force_d;
            row_q        <= row_d;
            col_q        <= col_d;
            wait_q       <= wait_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            char_q       <= char_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
        end
    end

    // Shadow contents are meaningless until their valid bit is set.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    assign o_character  = char_q;
    assign o_address    = addr_q;
    assign o_start      = start_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_status_display.sv
// Bench for lcd_status_display: builds each frame as text from the inputs and
// expects writes for exactly the cells that differ from what the LCD holds.
module tb_lcd_status_display;

    localparam int N_ROWS   = 2;
    localparam int N_COLS   = 16;
    localparam int SR_SHIFT = 15;
    localparam int N_CELLS  = N_ROWS * N_COLS;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_status_para;
    logic [63:0] i_time_para;
    logic        i_busy;
    logic        i_force;
    logic [7:0]  o_character;
    logic [7:0]  o_address;
    logic        o_start;
    logic        o_frame_done;

    always #5 clk = ~clk;

    lcd_status_display #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .SR_SHIFT(SR_SHIFT)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_status_para (i_status_para),
        .i_time_para   (i_time_para),
        .i_busy        (i_busy),
        .i_force       (i_force),
        .o_character   (o_character),
        .o_address     (o_address),
        .o_start       (o_start),
        .o_frame_done  (o_frame_done)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  disp [N_CELLS];
    logic [7:0]  lcd_mem [256];
    int          exp_n;
    int          strobe_cnt;
    logic [15:0] last_sa;
    logic [2:0]  mode;
    logic [3:0]  speed;
    logic [31:0] cur;
    logic [31:0] tot;
    int          busy_mode;
    int          busy_cnt;
    logic [7:0]  hs_char;
    logic [7:0]  hs_addr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_inputs();
        i_status_para = {4'b0000, speed, 5'b00000, mode};
        i_time_para   = {cur, tot};
    endtask

    function automatic string mmss(input logic [31:0] cnt);
        int s;
        int m;
        s = int'(cnt >> SR_SHIFT);
        m = s / 60;
        if (m > 99) return "99:59";
        return $sformatf("%02d:%02d", m, s % 60);
    endfunction

    function automatic logic [7:0] cell_addr(input int i);
        return (i < N_COLS) ? 8'(i) : 8'(64 + i - N_COLS);
    endfunction

    function automatic logic [127:0] lcd_str(input int row, input int col, input int len);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < len; k++) r = {r[119:0], lcd_mem[row * 64 + col + k]};
        return r;
    endfunction

    // Expected frame text from the current inputs; queue writes for cells that change.
    task automatic prepare_frame(input bit full);
        logic [7:0] tgt [N_CELLS];
        string      mt;
        string      ts;
        for (int i = 0; i < N_CELLS; i++) tgt[i] = 8'h20;
        case (mode)
            3'd1:    mt = "PLAY";
            3'd2:    mt = "PAUSE";
            3'd3:    mt = "STOP";
            3'd4:    mt = "RECORD";
            default: mt = "IDLE";
        endcase
        for (int k = 0; k < mt.len(); k++) tgt[k] = mt[k];
        if (mode == 3'd1) begin
            tgt[N_COLS - 2] = "x";
            tgt[N_COLS - 1] = 8'(48 + int'(speed));
        end
        ts = {mmss(cur), "/", mmss(tot)};
        for (int k = 0; k < 11; k++) tgt[N_COLS + k] = ts[k];
        exp_n      = 0;
        strobe_cnt = 0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (full || disp[i] != tgt[i]) begin
                exp_q.push_back({cell_addr(i), tgt[i]});
                disp[i] = tgt[i];
                exp_n++;
            end
        end
    endtask

    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!o_frame_done && cycles < 3000);
        if (!o_frame_done) check("frame_done_timeout", o_frame_done, 1'b1);
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_strobes"}, strobe_cnt, exp_n);
    endtask

    always @(negedge clk) begin
        if (!i_rst && o_start) begin
            strobe_cnt++;
            last_sa = {o_address, o_character};
            lcd_mem[o_address] = o_character;
            if (exp_q.size() == 0) check("strobe_while_idle", o_start, 1'b0);
            else check("strobe", {o_address, o_character}, exp_q.pop_front());
        end
    end

    // Busy responder: 0 = echo start for 3 cycles, 1 = never busy, 2 = always busy.
    always @(negedge clk) begin
        case (busy_mode)
            0: begin
                if (busy_cnt == 1) begin
                    check("hold_char", o_character, hs_char);
                    check("hold_addr", o_address, hs_addr);
                end
                if (busy_cnt > 0) busy_cnt--;
                if (o_start && !i_rst) begin
                    busy_cnt = 3;
                    hs_char  = o_character;
                    hs_addr  = o_address;
                end
                i_busy = (busy_cnt != 0);
            end
            1: begin
                busy_cnt = 0;
                i_busy   = 1'b0;
            end
            default: begin
                busy_cnt = 0;
                i_busy   = 1'b1;
            end
        endcase
    end

    initial begin
        int cyc;
        int waited;
        bit saw_done;
        i_rst     = 1'b1;
        i_force   = 1'b0;
        i_busy    = 1'b0;
        busy_mode = 0;
        busy_cnt  = 0;
        mode      = 3'd1;
        speed     = 4'd2;
        cur       = 32'd0;
        tot       = 32'd125 << 15;
        apply_inputs();
        for (int i = 0; i < N_CELLS; i++) disp[i] = 8'h20;
        for (int i = 0; i < 256; i++) lcd_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_start", o_start, 1'b0);
        check("rst_frame_done", o_frame_done, 1'b0);
        check("rst_char", o_character, 8'h20);
        check("rst_addr", o_address, 8'h00);

        prepare_frame(1);
        i_rst = 1'b0;
        wait_frame(cyc);
        frame_checks("first");
        check("row0_mode", lcd_str(0, 0, 4), "PLAY");
        check("row0_speed", lcd_str(0, 14, 2), "x2");
        check("row1_time", lcd_str(1, 0, 11), "00:00/02:05");

        prepare_frame(0);
        wait_frame(cyc);
        frame_checks("stable");
        check("idle_period", cyc, N_CELLS + 3);

        cur = 32'd1 << 15;
        apply_inputs();
        prepare_frame(0);
        wait_frame(cyc);
        frame_checks("plus1s");
        check("plus1s_write", last_sa, {8'h44, 8'h31});

        busy_mode = 1;
        tot = 32'd200 << 15;
        apply_inputs();
        prepare_frame(0);
        wait_frame(cyc);
        frame_checks("timeout");
        check("timeout_period", cyc, N_CELLS + 3 + 6 * exp_n);

        busy_mode = 0;
        cur = 32'd6000 << 15;
        apply_inputs();
        prepare_frame(0);
        wait_frame(cyc);
        frame_checks("clamp");
        check("clamp_text", lcd_str(1, 0, 5), "99:59");

        for (int r = 0; r < 8; r++) begin
            mode      = 3'($urandom_range(0, 7));
            speed     = 4'($urandom_range(1, 8));
            cur       = $urandom;
            tot       = $urandom;
            busy_mode = $urandom_range(0, 1);
            apply_inputs();
            prepare_frame(0);
            wait_frame(cyc);
            frame_checks($sformatf("rand%0d", r));
            if (busy_mode == 1) check($sformatf("rand%0d_period", r), cyc, N_CELLS + 3 + 6 * exp_n);
        end

        busy_mode = 0;
        mode  = 3'd1;
        speed = 4'd3;
        cur   = 32'd10 << 15;
        tot   = 32'd300 << 15;
        apply_inputs();
        prepare_frame(0);
        wait_frame(cyc);
        frame_checks("settle");

        prepare_frame(0);
        repeat (6) @(negedge clk);
        i_force = 1'b1;
        @(negedge clk);
        i_force = 1'b0;
        wait_frame(cyc);
        frame_checks("force_mark");

        busy_mode = 2;
        prepare_frame(1);
        saw_done = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (o_frame_done) saw_done = 1'b1;
        end
        check("busy_held_strobes", strobe_cnt, 0);
        check("busy_held_no_frame", saw_done, 1'b0);
        busy_mode = 0;
        wait_frame(cyc);
        frame_checks("force_redraw");

        mode = 3'd4;
        apply_inputs();
        prepare_frame(0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!o_start && waited < 500);
        if (!o_start) check("rst_test_start_timeout", o_start, 1'b1);
        @(negedge clk);
        i_rst     = 1'b1;
        busy_mode = 1;
        @(negedge clk);
        check("midrst_start", o_start, 1'b0);
        check("midrst_char", o_character, 8'h20);
        check("midrst_addr", o_address, 8'h00);
        check("midrst_frame_done", o_frame_done, 1'b0);
        @(negedge clk);
        exp_q.delete();
        busy_mode = 0;
        prepare_frame(1);
        i_rst = 1'b0;
        wait_frame(cyc);
        frame_checks("after_rst");
        check("after_rst_mode", lcd_str(0, 0, 6), "RECORD");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_status_display.md
LCD_STATUS_DISPLAY -- requirements
Module: lcd_status_display

Interface
REQ-001 Parameter N_ROWS, default 2: number of display rows; legal values are 1 or 2.
REQ-002 Parameter N_COLS, default 16: characters per row; legal range is 12..40.
REQ-003 Parameter SR_SHIFT, default 15: right-shift that converts a sample count to seconds.
REQ-004 Port i_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port i_status_para, input, 16 bits: [2:0] mode code (0 default, 1 play, 2 pause, 3 stop, 4 record); [11:8] play speed, 1..8.
REQ-007 Port i_time_para, input, 64 bits: [63:32] current sample count; [31:0] total sample count.
REQ-008 Port i_busy, input, 1 bit: the downstream LCD driver is executing a write.
REQ-009 Port i_force, input, 1 bit: one-cycle request for a full redraw.
REQ-010 Port o_character, output, 8 bits: ASCII code of the character being written.
REQ-011 Port o_address, output, 8 bits: LCD DDRAM address of that character.
REQ-012 Port o_start, output, 1 bit: one-cycle write strobe to the driver.
REQ-013 Port o_frame_done, output, 1 bit: one-cycle pulse at the end of each scan.

Function
REQ-014 Target frame content SHALL be the following.
- Row 0, starting at col 0: "PLAY", "PAUSE", "STOP" or "RECORD" for codes 1..4; "IDLE" for any other code.
- Row 0, col N_COLS-2..N_COLS-1: "x" followed by the speed digit when mode is play; blanks otherwise.
- Row 1, starting at col 0: "MM:SS/MM:SS" showing current/total; when N_ROWS=1 this text occupies row 0, col N_COLS-11 onward.
- Every other cell: 0x20.
REQ-015 Time conversion: s = count >> SR_SHIFT; seconds = s % 60; minutes = s / 60; when minutes > 99 the field SHALL show "99:59".
REQ-016 Address SHALL be row*0x40 + col.
REQ-017 The FSM SHALL have states SNAP, FMT, SCAN, ISSUE, WAIT_HI, WAIT_LO.
- SNAP: registers i_status_para and i_time_para (1 cycle), then goes to FMT.
- FMT: registers the digits via the sub-module (1 cycle), then goes to SCAN.
- SCAN: compares one cell per cycle against the shadow buffer, in row-major order.
REQ-018 When a scanned cell differs from the shadow buffer, or its valid bit is clear, the FSM SHALL go to ISSUE.
- ISSUE: drives o_character/o_address, pulses o_start for 1 cycle, updates the shadow cell, sets its valid bit, then goes to WAIT_HI.
REQ-019 WAIT_HI SHALL advance to WAIT_LO when i_busy=1, or after 4 cycles with i_busy still 0; WAIT_LO SHALL wait for i_busy=0 and then resume SCAN at the next cell.
REQ-020 If i_busy=1 at ISSUE entry, the FSM SHALL hold in ISSUE, without strobing, until i_busy=0.
REQ-021 o_character and o_address SHALL stay stable from the o_start cycle until WAIT_LO exits.
REQ-022 After the last cell, the block SHALL pulse o_frame_done and return to SNAP, so scanning runs continuously.
REQ-023 Inputs SHALL be sampled only in SNAP, so every frame is coherent.
REQ-024 i_force SHALL be latched in any state; the next SNAP clears all valid bits and then clears the latch.
REQ-025 A frame with no changes SHALL issue zero o_start pulses and take N_ROWS*N_COLS+3 cycles.

Reset
REQ-026 While i_rst=1, on each clock the block SHALL set the following.
- State = SNAP.
- o_start = 0, o_frame_done = 0.
- o_character = 0x20, o_address = 0x00.
- All valid bits cleared and the force latch cleared.
REQ-027 Reset mid-handshake SHALL drop o_start the next cycle; the first frame after reset SHALL write every cell.

Structure
REQ-028 Package lcd_pkg SHALL hold the following.
- Mode-code constants.
- ASCII constants: digits, letters, ':', '/', blank.
- FSM state enum.
- A function that computes the DDRAM address.
REQ-029 Sub-module sample_to_mmss SHALL perform the count-to-MMSS conversion with 1-cycle registered latency; it is instantiated twice.

Verification
REQ-030 Reset, then mode=1, speed=2, cur=0, tot=(125<<15), busy echoing start for 3 cycles -> 32 strobes; row 0 = "PLAY ... x2", row 1 = "00:00/02:05".
REQ-031 Stable inputs across a second frame -> zero strobes, and o_frame_done exactly 35 cycles later.
REQ-032 cur advanced by 1<<15 -> exactly one strobe, at address 0x44, with character "1".
REQ-033 cur = 6000<<15 -> "99:59" shown.
REQ-034 i_busy never asserted -> each write times out after 4 cycles; i_busy held high -> no strobe issues.
REQ-035 i_rst pulsed during WAIT_LO, and i_force pulsed mid-scan -> full 32-cell redraw follows.
